// File: rtl/aes_data_dpram.sv
// -----------------------------------------------------------------------------
// aes_data_dpram
// -----------------------------------------------------------------------------
// Single-clock true dual-port RAM that carries AES plaintext, ciphertext and key
// blocks between the HPS bridge (port A) and the AES core (port B). Both ports
// are Avalon-MM slaves with byte enables, a configurable read latency
// (READ_LAT = 1 or 2), readdatavalid and waitrequest. After every reset the
// whole array is zero-filled, one word per cycle, before traffic is accepted.
//
// Parameters
//   DATA_W    word width in bits (multiple of 8)
//   ADDR_W    address width, DEPTH = 2**ADDR_W words
//   READ_LAT  read latency in cycles, 1 or 2
//   BE_W      byteenable width, DATA_W/8 (derived, leave at default)
//
// Ports (x = a | b)
//   clk, reset_n        single clock, synchronous active-low reset
//   x_chipselect        port select
//   x_read / x_write    command strobes
//   x_address           word address
//   x_byteenable        byte lanes to update on a write
//   x_writedata         write data
//   x_readdata          read data, holds its last value between reads
//   x_readdatavalid     one-cycle qualifier, READ_LAT cycles after acceptance
//   x_waitrequest       high while the array is being cleared or in reset
//   a_irq, b_irq        doorbell interrupts
//
// Optional feature
//   AES_DPRAM_DOORBELL_EN: when defined, a write by one port to the last word
//   raises the other port's irq on the next cycle; a read of the last word by
//   a port clears that port's irq (a set in the same cycle wins). When not
//   defined, both irq outputs are tied low.
//
// Handshake: a command is accepted on a clk edge where chipselect is high,
// read or write is high and waitrequest is low. In RUN waitrequest is low, so
// every presented command is taken in the cycle it appears. read together
// with write on one port performs the write only and issues no read.
// -----------------------------------------------------------------------------
module aes_data_dpram #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 2,
  parameter int READ_LAT = 1,
  parameter int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              a_chipselect,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic [DATA_W-1:0] a_writedata,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  output logic              a_waitrequest,

  input  logic              b_chipselect,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic [DATA_W-1:0] b_writedata,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic              b_waitrequest,

  output logic              a_irq,
  output logic              b_irq
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // ---------------------------------------------------------------------------
  // Clear / run sequencer
  // ---------------------------------------------------------------------------
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wait_req;
  logic              clr_we;

  // reset_n is folded in so that a command presented in the cycle reset is
  // sampled is never taken.
  assign wait_req      = (state_q != ST_RUN) || !reset_n;
  assign a_waitrequest = wait_req;
  assign b_waitrequest = wait_req;
  assign clr_we        = (state_q == ST_CLEAR) && reset_n;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted commands
  // ---------------------------------------------------------------------------
  logic a_wr, a_rd, b_wr, b_rd;

  assign a_wr = a_chipselect && a_write && !wait_req;
  assign a_rd = a_chipselect && a_read && !a_write && !wait_req;
  assign b_wr = b_chipselect && b_write && !wait_req;
  assign b_rd = b_chipselect && b_read && !b_write && !wait_req;

  // ---------------------------------------------------------------------------
  // Storage. Port A's lanes are applied after port B's, so on a same-address
  // collision A wins on the lanes both enable and each other lane keeps its
  // own writer's byte. The clear write never coincides with a port write.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[ptr_q] <= '0;
    end
    for (int i = 0; i < BE_W; i++) begin
      if (b_wr && b_byteenable[i]) begin
        mem_q[b_address][i*8 +: 8] <= b_writedata[i*8 +: 8];
      end
      if (a_wr && a_byteenable[i]) begin
        mem_q[a_address][i*8 +: 8] <= a_writedata[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage 1: the array is sampled at the accepting edge, before any write
  // of that same edge lands, so a read-during-write returns the old word.
  // ---------------------------------------------------------------------------
  logic              a_rv1_q, a_rv1_d, b_rv1_q, b_rv1_d;
  logic [DATA_W-1:0] a_rd1_q, a_rd1_d, b_rd1_q, b_rd1_d;

  always_comb begin
    a_rv1_d = a_rd;
    b_rv1_d = b_rd;
    a_rd1_d = a_rd ? mem_q[a_address] : a_rd1_q;
    b_rd1_d = b_rd ? mem_q[b_address] : b_rd1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_rv1_q <= 1'b0;
      b_rv1_q <= 1'b0;
      a_rd1_q <= '0;
      b_rd1_q <= '0;
    end else begin
      a_rv1_q <= a_rv1_d;
      b_rv1_q <= b_rv1_d;
      a_rd1_q <= a_rd1_d;
      b_rd1_q <= b_rd1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output register stage for READ_LAT = 2
  // ---------------------------------------------------------------------------
  if (READ_LAT == 2) begin : g_lat2
    logic              a_rv2_q, a_rv2_d, b_rv2_q, b_rv2_d;
    logic [DATA_W-1:0] a_rd2_q, a_rd2_d, b_rd2_q, b_rd2_d;

    always_comb begin
      a_rv2_d = a_rv1_q;
      b_rv2_d = b_rv1_q;
      a_rd2_d = a_rv1_q ? a_rd1_q : a_rd2_q;
      b_rd2_d = b_rv1_q ? b_rd1_q : b_rd2_q;
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        a_rv2_q <= 1'b0;
        b_rv2_q <= 1'b0;
        a_rd2_q <= '0;
        b_rd2_q <= '0;
      end else begin
        a_rv2_q <= a_rv2_d;
        b_rv2_q <= b_rv2_d;
        a_rd2_q <= a_rd2_d;
        b_rd2_q <= b_rd2_d;
      end
    end

    assign a_readdata      = a_rd2_q;
    assign a_readdatavalid = a_rv2_q;
    assign b_readdata      = b_rd2_q;
    assign b_readdatavalid = b_rv2_q;
  end else begin : g_lat1
    assign a_readdata      = a_rd1_q;
    assign a_readdatavalid = a_rv1_q;
    assign b_readdata      = b_rd1_q;
    assign b_readdatavalid = b_rv1_q;
  end

  // ---------------------------------------------------------------------------
  // Doorbell interrupts
  // ---------------------------------------------------------------------------
`ifdef AES_DPRAM_DOORBELL_EN
  logic a_irq_q, a_irq_d, b_irq_q, b_irq_d;

  // Clear first, then set, so a set in the same cycle wins.
  always_comb begin
    a_irq_d = a_irq_q;
    b_irq_d = b_irq_q;
    if (a_rd && (a_address == LAST_ADDR)) a_irq_d = 1'b0;
    if (b_rd && (b_address == LAST_ADDR)) b_irq_d = 1'b0;
    if (b_wr && (b_address == LAST_ADDR)) a_irq_d = 1'b1;
    if (a_wr && (a_address == LAST_ADDR)) b_irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_irq_q <= 1'b0;
      b_irq_q <= 1'b0;
    end else begin
      a_irq_q <= a_irq_d;
      b_irq_q <= b_irq_d;
    end
  end

  assign a_irq = a_irq_q;
  assign b_irq = b_irq_q;
`else
  assign a_irq = 1'b0;
  assign b_irq = 1'b0;
`endif

endmodule

// File: tb/tb_aes_data_dpram.sv
// -----------------------------------------------------------------------------
// tb_aes_data_dpram
// Two instances of aes_data_dpram (READ_LAT = 1 and READ_LAT = 2) share one
// set of input drivers. Inputs change on the falling edge; outputs are sampled
// on the falling edge after the rising edge that produced them.
// Doorbell expectations follow AES_DPRAM_DOORBELL_EN.
// -----------------------------------------------------------------------------
module tb_aes_data_dpram;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 2;
  localparam int BE_W   = DATA_W / 8;

`ifdef AES_DPRAM_DOORBELL_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  localparam logic [127:0] V1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] V1P = 128'h77112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] VC  = 128'h00000000_55555555_AAAAAAAA_AAAAAAAA;
  localparam logic [127:0] X0  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] X1  = 128'hDEADBEEF_00000000_CAFEF00D_12345678;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              a_chipselect, a_read, a_write;
  logic [ADDR_W-1:0] a_address;
  logic [BE_W-1:0]   a_byteenable;
  logic [DATA_W-1:0] a_writedata;
  logic              b_chipselect, b_read, b_write;
  logic [ADDR_W-1:0] b_address;
  logic [BE_W-1:0]   b_byteenable;
  logic [DATA_W-1:0] b_writedata;

  logic [DATA_W-1:0] a_rdata1, b_rdata1, a_rdata2, b_rdata2;
  logic              a_rdv1, b_rdv1, a_rdv2, b_rdv2;
  logic              a_wait1, b_wait1, a_wait2, b_wait2;
  logic              a_irq1, b_irq1, a_irq2, b_irq2;

  aes_data_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_readdata(a_rdata1), .a_readdatavalid(a_rdv1), .a_waitrequest(a_wait1),
    .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_readdata(b_rdata1), .b_readdatavalid(b_rdv1), .b_waitrequest(b_wait1),
    .a_irq(a_irq1), .b_irq(b_irq1)
  );

  aes_data_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_readdata(a_rdata2), .a_readdatavalid(a_rdv2), .a_waitrequest(a_wait2),
    .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_readdata(b_rdata2), .b_readdatavalid(b_rdv2), .b_waitrequest(b_wait2),
    .a_irq(a_irq2), .b_irq(b_irq2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q1[$];
  logic [DATA_W-1:0] exp_q2[$];

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_a();
    a_chipselect = 1'b0; a_read = 1'b0; a_write = 1'b0;
    a_address = '0; a_byteenable = '0; a_writedata = '0;
  endtask

  task automatic idle_b();
    b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0;
    b_address = '0; b_byteenable = '0; b_writedata = '0;
  endtask

  task automatic set_a_write(input logic [ADDR_W-1:0] addr,
                             input logic [127:0] data, input logic [15:0] be);
    a_chipselect = 1'b1; a_write = 1'b1; a_read = 1'b0;
    a_address = addr; a_writedata = data; a_byteenable = be;
  endtask

  task automatic set_b_write(input logic [ADDR_W-1:0] addr,
                             input logic [127:0] data, input logic [15:0] be);
    b_chipselect = 1'b1; b_write = 1'b1; b_read = 1'b0;
    b_address = addr; b_writedata = data; b_byteenable = be;
  endtask

  task automatic a_wr(input logic [ADDR_W-1:0] addr, input logic [127:0] data,
                      input logic [15:0] be);
    set_a_write(addr, data, be);
    step();
    idle_a();
  endtask

  task automatic b_wr(input logic [ADDR_W-1:0] addr, input logic [127:0] data,
                      input logic [15:0] be);
    set_b_write(addr, data, be);
    step();
    idle_b();
  endtask

  // Single read on one port; checks both latencies and the hold behaviour.
  task automatic read_chk(input bit port_b, input logic [ADDR_W-1:0] addr,
                          input logic [127:0] exp, input string tag);
    if (port_b) begin
      b_chipselect = 1'b1; b_read = 1'b1; b_address = addr;
    end else begin
      a_chipselect = 1'b1; a_read = 1'b1; a_address = addr;
    end
    step();
    check_eq({tag, "_lat1_rdv"},  128'(port_b ? b_rdv1 : a_rdv1), 128'(1));
    check_eq({tag, "_lat1_data"}, port_b ? b_rdata1 : a_rdata1, exp);
    check_eq({tag, "_lat2_early"}, 128'(port_b ? b_rdv2 : a_rdv2), 128'(0));
    if (port_b) idle_b(); else idle_a();
    step();
    check_eq({tag, "_lat1_rdv_off"}, 128'(port_b ? b_rdv1 : a_rdv1), 128'(0));
    check_eq({tag, "_lat1_hold"},    port_b ? b_rdata1 : a_rdata1, exp);
    check_eq({tag, "_lat2_rdv"},     128'(port_b ? b_rdv2 : a_rdv2), 128'(1));
    check_eq({tag, "_lat2_data"},    port_b ? b_rdata2 : a_rdata2, exp);
  endtask

  // Counts waitrequest-high cycles after reset_n rises.
  task automatic release_and_count(input string tag);
    int cnt;
    reset_n = 1'b1;
    cnt = 0;
    while (a_wait1 && cnt < 20) begin
      step();
      cnt++;
    end
    check_eq({tag, "_clear_cycles"}, 128'(cnt), 128'(4));
    check_eq({tag, "_wait_a2"}, 128'(a_wait2), 128'(0));
    check_eq({tag, "_wait_b1"}, 128'(b_wait1), 128'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [127:0] m [4];
    logic [127:0] got;

    reset_n = 1'b0;
    idle_a();
    idle_b();
    step();
    step();

    // Reset state
    check_eq("rst_wait_a1", 128'(a_wait1), 128'(1));
    check_eq("rst_wait_b2", 128'(b_wait2), 128'(1));
    check_eq("rst_rdv_a1",  128'(a_rdv1),  128'(0));
    check_eq("rst_rdv_b2",  128'(b_rdv2),  128'(0));
    check_eq("rst_rdata_a1", a_rdata1, 128'(0));
    check_eq("rst_rdata_b2", b_rdata2, 128'(0));
    check_eq("rst_irq", 128'({a_irq1, b_irq1, a_irq2, b_irq2}), 128'(0));

    release_and_count("init");
    for (int i = 0; i < 4; i++) read_chk(1'b0, 2'(i), 128'(0), "init_zero");
    check_eq("clear_irq", 128'({a_irq1, b_irq1, a_irq2, b_irq2}), 128'(0));

    // Full write on A, read back on B
    a_wr(2'd1, V1, 16'hFFFF);
    read_chk(1'b1, 2'd1, V1, "wr_a_rd_b");

    // Byteenable = 0 is a no-op, single top lane update
    a_wr(2'd1, {16{8'hFF}}, 16'h0000);
    read_chk(1'b1, 2'd1, V1, "be_zero");
    a_wr(2'd1, {16{8'h77}}, 16'h8000);
    read_chk(1'b0, 2'd1, V1P, "be_top_lane");

    // Write collision on addr 2 (zero after clear)
    set_a_write(2'd2, {16{8'hAA}}, 16'h00FF);
    set_b_write(2'd2, {16{8'h55}}, 16'h0FF0);
    step();
    idle_a();
    idle_b();
    read_chk(1'b1, 2'd2, VC, "collision");

    // Mixed-port read-during-write: B reads addr 3 while A writes it
    a_wr(2'd3, 128'h1, 16'hFFFF);
    set_a_write(2'd3, 128'h2, 16'hFFFF);
    b_chipselect = 1'b1; b_read = 1'b1; b_address = 2'd3;
    step();
    check_eq("rdw_b_lat1", b_rdata1, 128'h1);
    idle_a();
    idle_b();
    step();
    check_eq("rdw_b_lat2", b_rdata2, 128'h1);
    read_chk(1'b1, 2'd3, 128'h2, "rdw_after");

    // read+write together on A: write performed, no read issued
    a_chipselect = 1'b1; a_read = 1'b1; a_write = 1'b1;
    a_address = 2'd0; a_writedata = X0; a_byteenable = 16'hFFFF;
    step();
    check_eq("rw_both_no_rdv1", 128'(a_rdv1), 128'(0));
    idle_a();
    step();
    check_eq("rw_both_no_rdv2", 128'(a_rdv2), 128'(0));

    // Chipselect low: write ignored
    a_write = 1'b1; a_address = 2'd0; a_writedata = '1; a_byteenable = 16'hFFFF;
    step();
    idle_a();

    // Opposite direction read-during-write: A reads addr 0 while B writes it
    set_b_write(2'd0, X1, 16'hFFFF);
    a_chipselect = 1'b1; a_read = 1'b1; a_address = 2'd0;
    step();
    check_eq("rdw_a_lat1", a_rdata1, X0);
    idle_a();
    idle_b();
    step();
    check_eq("rdw_a_lat2", a_rdata2, X0);

    m[0] = X1; m[1] = V1P; m[2] = VC; m[3] = 128'h2;

    // Back-to-back B reads of 0..3
    for (int i = 0; i < 4; i++) begin
      exp_q1.push_back(m[i]);
      exp_q2.push_back(m[i]);
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        b_chipselect = 1'b1; b_read = 1'b1; b_address = 2'(k);
      end else begin
        idle_b();
      end
      step();
      check_eq($sformatf("b2b_rdv1_%0d", k), 128'(b_rdv1), 128'(k < 4));
      check_eq($sformatf("b2b_rdv2_%0d", k), 128'(b_rdv2), 128'(k >= 1 && k < 5));
      if (b_rdv1 && exp_q1.size() != 0) begin
        got = exp_q1.pop_front();
        check_eq($sformatf("b2b_data1_%0d", k), b_rdata1, got);
      end
      if (b_rdv2 && exp_q2.size() != 0) begin
        got = exp_q2.pop_front();
        check_eq($sformatf("b2b_data2_%0d", k), b_rdata2, got);
      end
    end
    check_eq("b2b_q1_drained", 128'(exp_q1.size()), 128'(0));
    check_eq("b2b_q2_drained", 128'(exp_q2.size()), 128'(0));

    // Back-to-back reads with reset mid-stream
    b_chipselect = 1'b1; b_read = 1'b1; b_address = 2'd0;
    step();
    check_eq("mid_rdv1_0", 128'(b_rdv1), 128'(1));
    check_eq("mid_data1_0", b_rdata1, m[0]);
    b_address = 2'd1;
    step();
    check_eq("mid_data1_1", b_rdata1, m[1]);
    check_eq("mid_data2_0", b_rdata2, m[0]);
    reset_n = 1'b0;
    b_address = 2'd2;
    step();
    check_eq("mid_flush_rdv", 128'({b_rdv1, b_rdv2}), 128'(0));
    check_eq("mid_flush_d1", b_rdata1, 128'(0));
    check_eq("mid_flush_d2", b_rdata2, 128'(0));
    check_eq("mid_wait", 128'(b_wait1), 128'(1));
    b_address = 2'd3;
    step();
    check_eq("mid_flush_rdv_b", 128'({b_rdv1, b_rdv2}), 128'(0));
    idle_b();
    release_and_count("mid");
    check_eq("mid_no_rdv", 128'({b_rdv1, b_rdv2, a_rdv1, a_rdv2}), 128'(0));
    for (int i = 0; i < 4; i++) read_chk(1'b1, 2'(i), 128'(0), "mid_zero");
    check_eq("mid_irq", 128'({a_irq1, b_irq1, a_irq2, b_irq2}), 128'(0));

    // Doorbell
    a_wr(2'd3, 128'h5, 16'hFFFF);
    check_eq("db_a_wr_birq1", 128'(b_irq1), 128'(DB));
    check_eq("db_a_wr_birq2", 128'(b_irq2), 128'(DB));
    check_eq("db_a_wr_airq",  128'(a_irq1), 128'(0));
    read_chk(1'b1, 2'd3, 128'h5, "db_b_rd");
    check_eq("db_b_rd_clr", 128'(b_irq1), 128'(0));
    a_wr(2'd3, 128'h6, 16'hFFFF);
    check_eq("db_reset_birq", 128'(b_irq1), 128'(DB));
    set_a_write(2'd3, 128'h7, 16'hFFFF);
    b_chipselect = 1'b1; b_read = 1'b1; b_address = 2'd3;
    step();
    idle_a();
    idle_b();
    check_eq("db_set_wins1", 128'(b_irq1), 128'(DB));
    check_eq("db_set_wins2", 128'(b_irq2), 128'(DB));
    check_eq("db_set_wins_data", b_rdata1, 128'h6);
    b_wr(2'd3, 128'h8, 16'hFFFF);
    check_eq("db_b_wr_airq", 128'(a_irq1), 128'(DB));
    read_chk(1'b0, 2'd3, 128'h8, "db_a_rd");
    check_eq("db_a_rd_clr", 128'(a_irq1), 128'(0));
    check_eq("db_birq_kept", 128'(b_irq1), 128'(DB));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
